// File: rtl/synth_pkg.sv
// Shared synth constants and helpers for the oscillator/amp path and the I2S transmitter.
// Frame layout: 32 BCLKs per frame, mono sample duplicated into left and right slots.
package synth_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  localparam bit_cnt_t LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  // Word select leads the slot's MSB by one BCLK.
  function automatic logic lrclk_for(input bit_cnt_t cnt);
    bit_cnt_t ahead;
    ahead = cnt + 1'b1;
    return ahead[BIT_CNT_W-1];
  endfunction

  function automatic logic [3:0] slot_bit(input bit_cnt_t cnt);
    return 4'd15 - cnt[3:0];
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clocks and flags the toggle cycle.
// fall_stb/rise_stb are high in the cycle whose clock edge takes bclk 1->0 / 0->1.
module bclk_gen #(
  parameter int BCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CNT_W = $clog2(BCLK_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             term;

  assign term     = (div_cnt == TERM);
  assign fall_stb = term & bclk;
  assign rise_stb = term & ~bclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one-entry holding register feeding a frame buffer, shifted MSB first.
// A sample is taken at each frame wrap; an empty holding register repeats the last sample.
module i2s_tx
  import synth_pkg::*;
#(
  parameter int BCLK_DIV = 16,
  parameter int SAMPLE_W = synth_pkg::SAMPLE_W
) (
  input  logic                       i_clk50mhz,
  input  logic                       i_rst_n,
  input  logic signed [SAMPLE_W-1:0] i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_bclk,
  output logic                       o_lrclk,
  output logic                       o_sdata,
  output logic                       o_underrun
);

  logic                fall_stb;
  logic                bclk_rise_unused;
  logic [SAMPLE_W-1:0] hold_dat;
  logic [SAMPLE_W-1:0] frame_dat;
  logic                hold_full;
  bit_cnt_t            bit_cnt;
  bit_cnt_t            next_cnt;
  logic                accept;

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (i_clk50mhz),
    .rst_n    (i_rst_n),
    .bclk     (o_bclk),
    .fall_stb (fall_stb),
    .rise_stb (bclk_rise_unused)
  );

  assign o_ready  = ~hold_full;
  assign accept   = i_valid & ~hold_full;
  assign next_cnt = bit_cnt + 1'b1;

  always_ff @(posedge i_clk50mhz) begin
    if (!i_rst_n) begin
      hold_dat   <= '0;
      frame_dat  <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= LAST_BIT;
      o_lrclk    <= 1'b0;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= 1'b0;

      // Accept and frame transfer are exclusive: accept needs an empty register.
      if (accept) begin
        hold_dat  <= i_data;
        hold_full <= 1'b1;
      end

      if (fall_stb) begin
        bit_cnt <= next_cnt;
        o_lrclk <= lrclk_for(next_cnt);
        if (bit_cnt == LAST_BIT) begin
          if (hold_full) begin
            frame_dat <= hold_dat;
            hold_full <= 1'b0;
            o_sdata   <= hold_dat[SAMPLE_W-1];
          end else begin
            o_underrun <= 1'b1;
            o_sdata    <= frame_dat[SAMPLE_W-1];
          end
        end else begin
          o_sdata <= frame_dat[slot_bit(next_cnt)];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at the default divider (BCLK period 32 clocks, frame 1024 clocks).
module tb_i2s_tx;

  typedef struct {
    logic        offer;
    logic [15:0] data;
    logic [15:0] exp_word;
    int          exp_ur;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        valid = 1'b0;
  logic        ready, bclk, lrclk, sdata, underrun;

  int n_vec = 0;
  int n_bad = 0;

  int   cyc, ur_cnt, ur_last, ur_prev, ur_wide, sd_ones;
  int   rise_last, rise_prev, fall_last;
  logic prev_ur, prev_bclk;

  vec_t vecs [7];

  i2s_tx #(.BCLK_DIV(16), .SAMPLE_W(16)) dut (
    .i_clk50mhz (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_valid    (valid),
    .o_ready    (ready),
    .o_bclk     (bclk),
    .o_lrclk    (lrclk),
    .o_sdata    (sdata),
    .o_underrun (underrun)
  );

  always #10 clk = ~clk;

  // Cycle counter: cyc equals the number of clock edges since reset release.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc <= 0; ur_cnt <= 0; ur_last <= -1; ur_prev <= -1; ur_wide <= 0; sd_ones <= 0;
      rise_last <= -1; rise_prev <= -1; fall_last <= -1; prev_ur <= 1'b0; prev_bclk <= 1'b0;
    end else begin
      cyc       <= cyc + 1;
      prev_ur   <= underrun;
      prev_bclk <= bclk;
      if (underrun) begin
        ur_cnt  <= ur_cnt + 1;
        ur_prev <= ur_last;
        ur_last <= cyc;
        if (prev_ur) ur_wide <= ur_wide + 1;
      end
      if (sdata) sd_ones <= sd_ones + 1;
      if (bclk && !prev_bclk) begin
        rise_prev <= rise_last;
        rise_last <= cyc;
      end
      if (!bclk && prev_bclk) fall_last <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_bclk"},     32'(bclk),     32'd0);
    check({tag, "_lrclk"},    32'(lrclk),    32'd0);
    check({tag, "_sdata"},    32'(sdata),    32'd0);
    check({tag, "_ready"},    32'(ready),    32'd1);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic offer(input logic [15:0] d, output int acc);
    logic rdy_now;
    int   guard;
    valid = 1'b1;
    data  = d;
    guard = 0;
    do begin
      rdy_now = ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy_now && guard < 4000);
    valid = 1'b0;
    acc   = cyc;
    if (!rdy_now) check("offer_timeout", 32'(rdy_now), 32'd1);
  endtask

  // Samples each bit at its BCLK rising edge; bit n of frame f is driven from edge 32*(32f+n+1).
  task automatic capture(input int f, output logic [15:0] l, output logic [15:0] r,
                         output int lr_err);
    lr_err = 0;
    l = '0;
    r = '0;
    for (int n = 0; n < 32; n++) begin
      logic [4:0] nx;
      logic       exp_lr;
      wait_cyc(32 * (32 * f + n + 1) + 16);
      if (n < 16) l[15 - n] = sdata;
      else        r[31 - n] = sdata;
      nx     = 5'(n + 1);
      exp_lr = nx[4];
      if (lrclk !== exp_lr) lr_err++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int          a0, a1, a2, a3, e0, e1, e2;
    logic        rdy_mid;
    logic [15:0] l0, r0, l1, r1, l2, r2;

    vecs[0] = '{1'b1, 16'hA5C3, 16'hA5C3, 0};
    vecs[1] = '{1'b1, 16'h7FFF, 16'h7FFF, 0};
    vecs[2] = '{1'b1, 16'h8000, 16'h8000, 0};
    vecs[3] = '{1'b1, 16'h3FFF, 16'h3FFF, 0};
    vecs[4] = '{1'b0, 16'h0000, 16'h3FFF, 1};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h3FFF, 1};
    vecs[6] = '{1'b1, 16'h0001, 16'h0001, 0};

    // Idle after reset: wraps at edges 32, 1056, 2080 each underrun.
    do_reset("rst0");
    wait_cyc(2082);
    check("idle_ready",       32'(ready),            32'd1);
    check("idle_sdata_ones",  32'(sd_ones),          32'd0);
    check("idle_ur_count",    32'(ur_cnt),           32'd3);
    check("idle_ur_first",    32'(ur_prev),          32'd1056);
    check("idle_ur_interval", 32'(ur_last - ur_prev), 32'd1024);
    check("idle_ur_width",    32'(ur_wide),          32'd0);
    check("idle_bclk_period", 32'(rise_last - rise_prev), 32'd32);
    check("idle_bclk_high",   32'(fall_last - rise_last), 32'd16);

    do_reset("rst1");
    for (int i = 0; i < 7; i++) begin
      int          u0, acc, lre;
      logic [15:0] l, r;
      u0 = ur_cnt;
      if (vecs[i].offer) offer(vecs[i].data, acc);
      capture(i, l, r, lre);
      check($sformatf("vec%0d_left", i),     32'(l),           32'(vecs[i].exp_word));
      check($sformatf("vec%0d_right", i),    32'(r),           32'(vecs[i].exp_word));
      check($sformatf("vec%0d_lrclk", i),    32'(lre),         32'd0);
      check($sformatf("vec%0d_underrun", i), 32'(ur_cnt - u0), 32'(vecs[i].exp_ur));
    end
    check("vec_ur_width", 32'(ur_wide), 32'd0);

    // Back-to-back offers, then a sample held valid against a full holding register.
    do_reset("rst2");
    fork
      begin
        offer(16'h7FFF, a0);
        offer(16'h8000, a1);
        offer(16'h1234, a2);
      end
      begin
        wait_cyc(500);
        rdy_mid = ready;
      end
      begin
        capture(0, l0, r0, e0);
        capture(1, l1, r1, e1);
        capture(2, l2, r2, e2);
      end
    join
    check("b2b_acc_first",  32'(a0),      32'd1);
    check("b2b_acc_second", 32'(a1),      32'd33);
    check("held_acc",       32'(a2),      32'd1057);
    check("held_ready_mid", 32'(rdy_mid), 32'd0);
    check("b2b_f0_left",    32'(l0),      32'h7FFF);
    check("b2b_f0_right",   32'(r0),      32'h7FFF);
    check("b2b_f1_left",    32'(l1),      32'h8000);
    check("b2b_f1_right",   32'(r1),      32'h8000);
    check("held_f2_left",   32'(l2),      32'h1234);
    check("held_f2_right",  32'(r2),      32'h1234);
    check("b2b_lrclk",      32'(e0 + e1 + e2), 32'd0);
    check("b2b_underrun",   32'(ur_cnt),  32'd0);

    // Reset at bit_cnt 20 of a 5A5A frame with 0F0F pending.
    offer(16'h5A5A, a3);
    wait_cyc(3300);
    offer(16'h0F0F, a3);
    wait_cyc(3749);
    check("mid_pre_sdata", 32'(sdata), 32'd1);
    check("mid_pre_lrclk", 32'(lrclk), 32'd1);
    check("mid_pre_ready", 32'(ready), 32'd0);
    do_reset("rst3");
    capture(0, l0, r0, e0);
    check("post_rst_left",     32'(l0),      32'h0000);
    check("post_rst_right",    32'(r0),      32'h0000);
    check("post_rst_lrclk",    32'(e0),      32'd0);
    check("post_rst_ur_count", 32'(ur_cnt),  32'd1);
    check("post_rst_ur_at",    32'(ur_last), 32'd32);
    check("post_rst_ones",     32'(sd_ones), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
